// File: rtl/cw310_pkg.sv
// Shared register map, constant values and CTRL bit positions for the CW310 USB register block.
package cw310_pkg;

    localparam int unsigned REG_WORD_W = 32;
    localparam int unsigned NBYTES_W   = 3;

    localparam logic [7:0] ADDR_IDENTIFY = 8'h00;
    localparam logic [7:0] ADDR_VERSION  = 8'h01;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h02;
    localparam logic [7:0] ADDR_STATUS   = 8'h03;
    localparam logic [7:0] ADDR_LED_CTRL = 8'h04;
    localparam logic [7:0] ADDR_CTRL     = 8'h05;

    localparam logic [31:0] IDENTIFY_VALUE = 32'h0031_0D0E;
    localparam logic [7:0]  VERSION_VALUE  = 8'h01;

    localparam int unsigned CTRL_TRIG_BIT = 0;
    localparam int unsigned CTRL_OSC_BIT  = 1;

    // Read-side view of one register: zero-extended contents plus its width in bytes.
    typedef struct packed {
        logic [REG_WORD_W-1:0] word;
        logic [NBYTES_W-1:0]   nbytes;
    } reg_view_t;

    function automatic logic [7:0] byte_sel(input logic [REG_WORD_W-1:0] word,
                                            input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cw310_usb_reg_fe.sv
// USB parallel-bus front end: registers the pins once and decodes write strobe and data-bus enable.
module cw310_usb_reg_fe #(
    parameter int unsigned pBYTECNT_SIZE   = 7,
    parameter int unsigned pUSB_ADDR_WIDTH = 20
) (
    input  logic                                      clk,
    input  logic                                      i_rst_n,
    input  logic [pUSB_ADDR_WIDTH-1:0]                i_usb_a,
    input  logic [7:0]                                i_usb_d,
    input  logic                                      i_usb_nrd,
    input  logic                                      i_usb_nwr,
    input  logic                                      i_usb_nce,
    output logic [pUSB_ADDR_WIDTH-pBYTECNT_SIZE-1:0]  o_reg_addr,
    output logic [pBYTECNT_SIZE-1:0]                  o_byte_idx,
    output logic [7:0]                                o_wdata,
    output logic                                      o_wr_c,
    output logic                                      o_d_oe_c
);

    logic [pUSB_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                 r_data;
    logic                       r_nrd;
    logic                       r_nwr;
    logic                       r_nce;

    // Strobes reset to idle so a transaction in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_nrd  <= 1'b1;
            r_nwr  <= 1'b1;
            r_nce  <= 1'b1;
        end else begin
            r_addr <= i_usb_a;
            r_data <= i_usb_d;
            r_nrd  <= i_usb_nrd;
            r_nwr  <= i_usb_nwr;
            r_nce  <= i_usb_nce;
        end
    end

    assign o_reg_addr = r_addr[pUSB_ADDR_WIDTH-1:pBYTECNT_SIZE];
    assign o_byte_idx = r_addr[pBYTECNT_SIZE-1:0];
    assign o_wdata    = r_data;
    assign o_wr_c     = ~r_nce & ~r_nwr;
    // Reset also releases the bus immediately, not one edge later.
    assign o_d_oe_c   = i_rst_n & ~r_nce & ~r_nrd;

endmodule

// File: rtl/cw310_top.sv
// CW310 USB register block top: register file, LED/trigger/clock outputs.
// Optional heartbeat on USRLED[0] enabled by defining CW310_HEARTBEAT_EN.
module cw310_top
    import cw310_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE   = 7,
    parameter int unsigned pUSB_ADDR_WIDTH = 20,
    parameter int unsigned pHEART_BIT      = 23
) (
    input  logic                       usb_clk,
    input  logic                       USRSW2,
    inout  wire  [7:0]                 USB_D,
    input  logic [pUSB_ADDR_WIDTH-1:0] USB_A,
    input  logic                       USB_nRD,
    input  logic                       USB_nWR,
    input  logic                       USB_nCE,
    input  logic                       usb_trigger,
    input  logic [7:0]                 USRDIP,
    output logic [7:0]                 USRLED,
    input  logic                       PLL_CLK1,
    input  logic                       CWIO_HS2,
    output logic                       CWIO_HS1,
    output logic                       CWIO_IO4,
    input  logic                       vauxp0,
    input  logic                       vauxn0,
    input  logic                       vauxp1,
    input  logic                       vauxn1,
    input  logic                       vauxp8,
    input  logic                       vauxn8,
    input  logic                       SYSCLK_P,
    input  logic                       SYSCLK_N,
    input  logic                       vddr_pgood,
    output logic                       LVDS_XO_200M_ENA
);

    localparam int unsigned REG_AW = pUSB_ADDR_WIDTH - pBYTECNT_SIZE;

    logic [REG_AW-1:0]        w_reg_addr;
    logic [pBYTECNT_SIZE-1:0] w_byte_idx;
    logic [7:0]               w_wdata;
    logic                     w_wr;
    logic                     w_d_oe;

    logic [31:0] r_scratch;
    logic [7:0]  r_led_ctrl;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_rdata;
    logic [7:0]  r_usrled;
    logic        r_io4;

    cw310_usb_reg_fe #(
        .pBYTECNT_SIZE   (pBYTECNT_SIZE),
        .pUSB_ADDR_WIDTH (pUSB_ADDR_WIDTH)
    ) u_fe (
        .clk        (usb_clk),
        .i_rst_n    (USRSW2),
        .i_usb_a    (USB_A),
        .i_usb_d    (USB_D),
        .i_usb_nrd  (USB_nRD),
        .i_usb_nwr  (USB_nWR),
        .i_usb_nce  (USB_nCE),
        .o_reg_addr (w_reg_addr),
        .o_byte_idx (w_byte_idx),
        .o_wdata    (w_wdata),
        .o_wr_c     (w_wr),
        .o_d_oe_c   (w_d_oe)
    );

    assign USB_D = w_d_oe ? r_rdata : 8'hzz;

    logic [2:0] w_addr_lo;
    logic       w_addr_hi_zero;
    logic       w_sel_scratch;
    logic       w_sel_led;
    logic       w_sel_ctrl;
    logic       w_idx_zero;

    assign w_addr_lo      = 3'(w_reg_addr);
    assign w_addr_hi_zero = (w_reg_addr >> 3) == '0;
    assign w_sel_scratch  = w_addr_hi_zero && (w_addr_lo == 3'(ADDR_SCRATCH));
    assign w_sel_led      = w_addr_hi_zero && (w_addr_lo == 3'(ADDR_LED_CTRL));
    assign w_sel_ctrl     = w_addr_hi_zero && (w_addr_lo == 3'(ADDR_CTRL));
    assign w_idx_zero     = w_byte_idx == '0;

    // Read mux: unmapped addresses report zero width so every byte reads 0x00.
    reg_view_t  w_view;
    logic [7:0] w_rbyte;

    always_comb begin
        w_view = '{word: '0, nbytes: '0};
        if (w_addr_hi_zero) begin
            case (w_addr_lo)
                3'(ADDR_IDENTIFY): w_view = '{word: IDENTIFY_VALUE, nbytes: 3'd4};
                3'(ADDR_VERSION):  w_view = '{word: 32'(VERSION_VALUE), nbytes: 3'd1};
                3'(ADDR_SCRATCH):  w_view = '{word: r_scratch, nbytes: 3'd4};
                3'(ADDR_STATUS):   w_view = '{word: {16'h0, USRDIP, 7'h0, vddr_pgood}, nbytes: 3'd2};
                3'(ADDR_LED_CTRL): w_view = '{word: 32'(r_led_ctrl), nbytes: 3'd1};
                3'(ADDR_CTRL):     w_view = '{word: 32'(r_ctrl), nbytes: 3'd1};
                default:           w_view = '{word: '0, nbytes: '0};
            endcase
        end
        w_rbyte = 8'h00;
        if (w_byte_idx < pBYTECNT_SIZE'(w_view.nbytes)) begin
            w_rbyte = byte_sel(w_view.word, w_byte_idx[1:0]);
        end
    end

    logic w_led0;

`ifdef CW310_HEARTBEAT_EN
    logic [31:0] r_heartbeat;

    always_ff @(posedge usb_clk) begin
        if (!USRSW2) begin
            r_heartbeat <= '0;
        end else begin
            r_heartbeat <= r_heartbeat + 32'd1;
        end
    end

    assign w_led0 = r_heartbeat[pHEART_BIT];
`else
    localparam int unsigned unused_heart_bit = pHEART_BIT;

    assign w_led0 = r_led_ctrl[0];
`endif

    logic [7:0] w_usrled_next;
    assign w_usrled_next = {r_led_ctrl[7:3], r_ctrl[CTRL_TRIG_BIT], vddr_pgood, w_led0};

    // Writes and the read-data register share one edge, so a colliding read sees the old value.
    always_ff @(posedge usb_clk) begin
        if (!USRSW2) begin
            r_scratch  <= '0;
            r_led_ctrl <= '0;
            r_ctrl     <= '0;
            r_rdata    <= '0;
            r_usrled   <= '0;
            r_io4      <= 1'b0;
        end else begin
            if (w_wr && w_sel_scratch && (w_byte_idx < pBYTECNT_SIZE'(4))) begin
                r_scratch[{w_byte_idx[1:0], 3'b000} +: 8] <= w_wdata;
            end
            if (w_wr && w_sel_led && w_idx_zero) begin
                r_led_ctrl <= w_wdata;
            end
            if (w_wr && w_sel_ctrl && w_idx_zero) begin
                r_ctrl <= w_wdata;
            end
            r_rdata  <= w_rbyte;
            r_usrled <= w_usrled_next;
            r_io4    <= r_ctrl[CTRL_TRIG_BIT] | usb_trigger;
        end
    end

    assign USRLED           = r_usrled;
    assign CWIO_IO4         = r_io4;
    assign LVDS_XO_200M_ENA = r_ctrl[CTRL_OSC_BIT];

    // Target clock path stays flop-free.
    assign CWIO_HS1 = USRDIP[1] ? (USRDIP[0] ? CWIO_HS2 : PLL_CLK1) : 1'b0;

    logic w_unused;
    assign w_unused = ^{vauxp0, vauxn0, vauxp1, vauxn1, vauxp8, vauxn8,
                        SYSCLK_P, SYSCLK_N, r_ctrl[7:2], r_led_ctrl[2:0]};

endmodule

// File: tb/tb_cw310_top.sv
// Self-checking bench for cw310_top with a byte-level reference model of the register map.
module tb_cw310_top;

    logic        usb_clk = 1'b0;
    logic        USRSW2;
    wire  [7:0]  usb_d;
    logic [7:0]  d_drv;
    logic        d_oe;
    logic [19:0] USB_A;
    logic        USB_nRD, USB_nWR, USB_nCE, usb_trigger;
    logic [7:0]  USRDIP;
    logic [7:0]  USRLED;
    logic        PLL_CLK1, CWIO_HS2, CWIO_HS1, CWIO_IO4;
    logic        vddr_pgood, LVDS_XO_200M_ENA;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_scratch [4];
    logic [7:0] m_led;
    logic [7:0] m_ctrl;

    assign usb_d = d_oe ? d_drv : 8'hzz;

    always #5 usb_clk = ~usb_clk;

    cw310_top #(
        .pBYTECNT_SIZE   (7),
        .pUSB_ADDR_WIDTH (20),
        .pHEART_BIT      (3)
    ) dut (
        .usb_clk          (usb_clk),
        .USRSW2           (USRSW2),
        .USB_D            (usb_d),
        .USB_A            (USB_A),
        .USB_nRD          (USB_nRD),
        .USB_nWR          (USB_nWR),
        .USB_nCE          (USB_nCE),
        .usb_trigger      (usb_trigger),
        .USRDIP           (USRDIP),
        .USRLED           (USRLED),
        .PLL_CLK1         (PLL_CLK1),
        .CWIO_HS2         (CWIO_HS2),
        .CWIO_HS1         (CWIO_HS1),
        .CWIO_IO4         (CWIO_IO4),
        .vauxp0           (1'b0),
        .vauxn0           (1'b0),
        .vauxp1           (1'b0),
        .vauxn1           (1'b0),
        .vauxp8           (1'b0),
        .vauxn8           (1'b0),
        .SYSCLK_P         (1'b0),
        .SYSCLK_N         (1'b1),
        .vddr_pgood       (vddr_pgood),
        .LVDS_XO_200M_ENA (LVDS_XO_200M_ENA)
    );

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    function automatic logic [7:0] exp_read(input int addr, input int idx);
        logic [31:0] w;
        int          n;
        case (addr)
            0:       begin w = 32'h0031_0D0E; n = 4; end
            1:       begin w = 32'h01; n = 1; end
            2:       begin w = {m_scratch[3], m_scratch[2], m_scratch[1], m_scratch[0]}; n = 4; end
            3:       begin w = {16'h0, USRDIP, 7'h0, vddr_pgood}; n = 2; end
            4:       begin w = {24'h0, m_led}; n = 1; end
            5:       begin w = {24'h0, m_ctrl}; n = 1; end
            default: begin w = 32'h0; n = 0; end
        endcase
        if (idx >= n) return 8'h00;
        return 8'(w >> (8 * idx));
    endfunction

    task automatic model_write(input int addr, input int idx, input logic [7:0] data);
        if (addr == 2 && idx < 4) m_scratch[idx] = data;
        if (addr == 4 && idx == 0) m_led = data;
        if (addr == 5 && idx == 0) m_ctrl = data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_scratch[i] = 8'h00;
        m_led  = 8'h00;
        m_ctrl = 8'h00;
    endtask

    task automatic usb_write(input int addr, input int idx, input logic [7:0] data);
        USB_A   = 20'((addr << 7) | idx);
        d_drv   = data;
        d_oe    = 1'b1;
        USB_nCE = 1'b0;
        USB_nWR = 1'b0;
        tick();
        USB_nCE = 1'b1;
        USB_nWR = 1'b1;
        d_oe    = 1'b0;
        tick();
        model_write(addr, idx, data);
    endtask

    task automatic usb_read(input int addr, input int idx, output logic [7:0] data);
        USB_A   = 20'((addr << 7) | idx);
        USB_nCE = 1'b0;
        USB_nRD = 1'b0;
        tick();
        tick();
        data    = usb_d;
        USB_nCE = 1'b1;
        USB_nRD = 1'b1;
        tick();
    endtask

    task automatic apply_reset();
        USRSW2 = 1'b0;
        tick();
        tick();
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        apply_reset();
        n_checks++;
        if (CWIO_IO4 !== 1'b0) begin n_fail++; $display("FAIL reset_io4 got=%b exp=0", CWIO_IO4); end
        n_checks++;
        if (USRLED !== 8'h00) begin n_fail++; $display("FAIL reset_usrled got=%h exp=00", USRLED); end
        n_checks++;
        if (LVDS_XO_200M_ENA !== 1'b0) begin n_fail++; $display("FAIL reset_lvds got=%b exp=0", LVDS_XO_200M_ENA); end
        USRSW2 = 1'b1;
        tick();
        for (int a = 2; a <= 5; a++) begin
            if (a == 3) continue;
            usb_read(a, 0, rd);
            n_checks++;
            if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=00", a, rd); end
        end
        n_checks++;
        if (CWIO_IO4 !== 1'b0) begin n_fail++; $display("FAIL reset_io4_after got=%b exp=0", CWIO_IO4); end
    endtask

    task automatic test_identify();
        logic [7:0] rd;
        logic [7:0] exp_id [4];
        exp_id = '{8'h0E, 8'h0D, 8'h31, 8'h00};
        for (int i = 0; i < 4; i++) begin
            usb_read(0, i, rd);
            n_checks++;
            if (rd !== exp_id[i]) begin n_fail++; $display("FAIL identify_b%0d got=%h exp=%h", i, rd, exp_id[i]); end
        end
        usb_read(1, 0, rd);
        n_checks++;
        if (rd !== 8'h01) begin n_fail++; $display("FAIL version got=%h exp=01", rd); end
        usb_read(1, 1, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL version_b1 got=%h exp=00", rd); end
    endtask

    task automatic test_scratch();
        logic [7:0] rd;
        logic [7:0] pat [4];
        pat = '{8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 4; i++) usb_write(2, i, pat[i]);
        for (int i = 0; i < 4; i++) begin
            usb_read(2, i, rd);
            n_checks++;
            if (rd !== pat[i]) begin n_fail++; $display("FAIL scratch_b%0d got=%h exp=%h", i, rd, pat[i]); end
        end
        usb_write(0, 0, 8'hAA);
        usb_read(0, 0, rd);
        n_checks++;
        if (rd !== 8'h0E) begin n_fail++; $display("FAIL identify_ro got=%h exp=0e", rd); end
        usb_read(2, 4, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL scratch_b4 got=%h exp=00", rd); end
    endtask

    task automatic test_ctrl_trigger();
        usb_write(5, 0, 8'h03);
        tick();
        n_checks++;
        if (CWIO_IO4 !== 1'b1) begin n_fail++; $display("FAIL ctrl_io4 got=%b exp=1", CWIO_IO4); end
        n_checks++;
        if (LVDS_XO_200M_ENA !== 1'b1) begin n_fail++; $display("FAIL ctrl_lvds got=%b exp=1", LVDS_XO_200M_ENA); end
        usb_write(5, 0, 8'h00);
        tick();
        n_checks++;
        if (CWIO_IO4 !== 1'b0 || LVDS_XO_200M_ENA !== 1'b0) begin
            n_fail++; $display("FAIL ctrl_clear io4=%b lvds=%b exp=0,0", CWIO_IO4, LVDS_XO_200M_ENA);
        end
        usb_trigger = 1'b1;
        #1;
        n_checks++;
        if (CWIO_IO4 !== 1'b0) begin n_fail++; $display("FAIL trig_early got=%b exp=0", CWIO_IO4); end
        tick();
        usb_trigger = 1'b0;
        n_checks++;
        if (CWIO_IO4 !== 1'b1) begin n_fail++; $display("FAIL trig_pulse got=%b exp=1", CWIO_IO4); end
        tick();
        n_checks++;
        if (CWIO_IO4 !== 1'b0) begin n_fail++; $display("FAIL trig_end got=%b exp=0", CWIO_IO4); end
    endtask

    task automatic test_clkmux_status();
        logic [7:0] rd;
        logic [7:0] dips [4];
        dips = '{8'h03, 8'h02, 8'h01, 8'h00};
        for (int d = 0; d < 4; d++) begin
            USRDIP = dips[d];
            for (int v = 0; v < 4; v++) begin
                CWIO_HS2 = v[0];
                PLL_CLK1 = v[1];
                #1;
                n_checks++;
                if (CWIO_HS1 !== (USRDIP[1] ? (USRDIP[0] ? v[0] : v[1]) : 1'b0)) begin
                    n_fail++; $display("FAIL clkmux dip=%h hs2=%b pll=%b got=%b", USRDIP, v[0], v[1], CWIO_HS1);
                end
            end
        end
        USRDIP = 8'h03;
        usb_read(3, 1, rd);
        n_checks++;
        if (rd !== 8'h03) begin n_fail++; $display("FAIL status_b1 got=%h exp=03", rd); end
        for (int p = 0; p < 2; p++) begin
            vddr_pgood = p[0];
            usb_read(3, 0, rd);
            n_checks++;
            if (rd !== {7'h0, p[0]}) begin n_fail++; $display("FAIL status_b0 pgood=%0d got=%h", p, rd); end
        end
    endtask

    task automatic test_heartbeat();
`ifdef CW310_HEARTBEAT_EN
        logic prev;
        int   last;
        int   toggles;
        prev    = USRLED[0];
        last    = -1;
        toggles = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (USRLED[0] !== prev) begin
                prev = USRLED[0];
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 8) begin n_fail++; $display("FAIL heartbeat_period got=%0d exp=8", c - last); end
                end
                last = c;
                toggles++;
            end
        end
        n_checks++;
        if (toggles < 9) begin n_fail++; $display("FAIL heartbeat_toggles got=%0d exp>=9", toggles); end
`else
        usb_write(4, 0, 8'hFF);
        tick();
        n_checks++;
        if (USRLED[0] !== 1'b1 || USRLED[7:3] !== 5'h1F) begin
            n_fail++; $display("FAIL led_ff got=%h exp led0=1 upper=1f", USRLED);
        end
        usb_write(4, 0, 8'h00);
        tick();
        n_checks++;
        if (USRLED[0] !== 1'b0) begin n_fail++; $display("FAIL led_00 got=%b exp=0", USRLED[0]); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic [7:0] exp_b;
        logic [7:0] wd;
        int         addr;
        int         idx;
        for (int it = 0; it < 60; it++) begin
            USRDIP     = 8'($urandom);
            vddr_pgood = 1'($urandom);
            addr       = ($urandom_range(0, 9) == 0) ? 32'h100 + 2 : int'($urandom_range(0, 7));
            idx        = int'($urandom_range(0, 5));
            wd         = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                usb_write(addr, idx, wd);
            end else begin
                exp_b = exp_read(addr, idx);
                usb_read(addr, idx, rd);
                n_checks++;
                if (rd !== exp_b) begin
                    n_fail++; $display("FAIL rand_read addr=%0h idx=%0d got=%h exp=%h", addr, idx, rd, exp_b);
                end
            end
            tick();
            n_checks++;
            if (USRLED[7:1] !== {m_led[7:3], m_ctrl[0], vddr_pgood}
`ifndef CW310_HEARTBEAT_EN
                || USRLED[0] !== m_led[0]
`endif
                || CWIO_IO4 !== m_ctrl[0] || LVDS_XO_200M_ENA !== m_ctrl[1]) begin
                n_fail++;
                $display("FAIL rand_outputs led=%h io4=%b lvds=%b exp led_ctrl=%h ctrl=%h pgood=%b",
                         USRLED, CWIO_IO4, LVDS_XO_200M_ENA, m_led, m_ctrl, vddr_pgood);
            end
        end
    endtask

    task automatic test_reset_after_writes();
        usb_write(2, 0, 8'hA5);
        usb_write(4, 0, 8'hF0);
        usb_write(5, 0, 8'h01);
        tick();
        test_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        USRSW2      = 1'b0;
        USB_A       = '0;
        d_drv       = '0;
        d_oe        = 1'b0;
        USB_nRD     = 1'b1;
        USB_nWR     = 1'b1;
        USB_nCE     = 1'b1;
        usb_trigger = 1'b0;
        USRDIP      = 8'h00;
        PLL_CLK1    = 1'b0;
        CWIO_HS2    = 1'b0;
        vddr_pgood  = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_identify();
        test_scratch();
        test_ctrl_trigger();
        test_clkmux_status();
        test_heartbeat();
        test_random();
        test_reset_after_writes();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
